register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
Parametrised successor to the single-write MIPS register file, for the pipelined datapath.
- Depth 2^A registers of N bits; optional hardwired-zero register 0.
- Two read ports and two write ports, with port-1 priority on write collision.
- Optional write-to-read bypass so a read returns the value being written in the same cycle.
- Built-in clear sequencer zeroes the whole file one register per cycle on request, with busy/done handshake.

Parameters:
N, 32, data width in bits.
A, 5, address width; depth = 2^A registers.
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.
BYPASS, 1, 1 = combinational write-to-read forwarding; 0 = reads return stored contents only.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
rd_addr0  input  A  read port 0 address.
rd_addr1  input  A  read port 1 address.
rd_data0  output  N  read port 0 data (combinational).
rd_data1  output  N  read port 1 data (combinational).
wr_addr0  input  A  write port 0 address.
wr_data0  input  N  write port 0 data.
wr_ena0  input  1  write port 0 enable.
wr_addr1  input  A  write port 1 address.
wr_data1  input  N  write port 1 data.
wr_ena1  input  1  write port 1 enable.
clear_req  input  1  request a full-file clear; sampled only in IDLE.
busy  output  1  high while the clear sequencer is running.
clear_done  output  1  one-cycle pulse after the last register is cleared.

Behaviour:
- Reset: one clk edge with rst=1 forces the following; rst has priority over every other input, including mid-clear.
  - All registers go to 0.
  - State goes to IDLE and the clear index to 0.
  - busy=0 and clear_done=0.
- Writes in IDLE:
  - On each edge, reg[wr_addrK] <= wr_dataK for each K with wr_enaK=1.
  - If both ports are enabled with the same address, only port 1's data is stored.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Reads:
  - rd_dataK is combinational from rd_addrK and the current contents; zero read latency.
  - Address 0 with ZERO_REG=1 always returns 0.
- Bypass (BYPASS=1, IDLE only): if rd_addrK matches an enabled write address, rd_dataK returns that write data.
  - Port 1 beats port 0 when both match.
  - Address 0 with ZERO_REG=1 still returns 0.
  - With BYPASS=0, the written value is visible the cycle after the edge.
- Clear FSM: states IDLE, CLEAR.
  - IDLE & clear_req at an edge: go to CLEAR, idx <= 0. Any writes presented at that same edge are performed.
  - Each CLEAR edge: reg[idx] <= 0, idx <= idx+1.
  - When idx = 2^A-1: go to IDLE and set clear_done <= 1 for one cycle.
  - busy = (state == CLEAR), registered. It is high for exactly 2^A cycles, starting the cycle after the request edge.
  - clear_done rises in the first cycle busy is low.
- During CLEAR:
  - wr_ena0 and wr_ena1 are ignored; the writes are dropped, not queued.
  - Bypass is disabled.
  - clear_req is ignored; no re-trigger.
  - Reads return current contents: registers already cleared read 0, the rest keep their old value.
- clear_req held high continuously: a new clear starts in the clear_done cycle, since the FSM is back in IDLE.
- idx is A bits wide; it wraps to 0 on leaving CLEAR.

Test Plan:
1. Reset, then write 0xDEADBEEF to address 5 on port 0 -> next cycle rd_addr0=5 reads 0xDEADBEEF; every other address reads 0.
2. BYPASS=1: in one cycle write 0x12345678 to address 9 on port 1 while rd_addr1=9 -> rd_data1=0x12345678 in that same cycle. Repeat with BYPASS=0 -> old value that cycle, new value the next cycle.
3. Collision: port 0 writes 0xAAAA0000 and port 1 writes 0x5555FFFF, both to address 3 -> address 3 holds 0x5555FFFF. Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> address 0 reads 0, including on the bypass path.
4. Clear with A=5, after filling registers 1..31 with nonzero values:
   - Pulse clear_req -> busy high for exactly 32 cycles, then clear_done high for exactly 1 cycle, then all addresses read 0.
   - Mid-clear, reading address 31 returns its old value.
   - A write issued mid-clear is absent afterwards.
5. Reset asserted at clear cycle 10 -> next cycle busy=0, clear_done=0, all registers 0. A clear_req at that point starts a fresh 32-cycle sequence.
6. clear_req and a write to address 7 (0x0000BEEF) at the same IDLE edge -> address 7 holds 0x0000BEEF until the clear reaches idx 7, then reads 0.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Bus bundle for the dual-port register file: read/write ports plus clear handshake.
interface register_file_mp_if #(
    parameter int N = 32,
    parameter int A = 5
);
    logic [A-1:0] rd_addr0;
    logic [A-1:0] rd_addr1;
    logic [N-1:0] rd_data0;
    logic [N-1:0] rd_data1;
    logic [A-1:0] wr_addr0;
    logic [N-1:0] wr_data0;
    logic         wr_ena0;
    logic [A-1:0] wr_addr1;
    logic [N-1:0] wr_data1;
    logic         wr_ena1;
    logic         clear_req;
    logic         busy;
    logic         clear_done;

    modport master (
        output rd_addr0, rd_addr1,
        output wr_addr0, wr_data0, wr_ena0,
        output wr_addr1, wr_data1, wr_ena1,
        output clear_req,
        input  rd_data0, rd_data1, busy, clear_done
    );

    modport slave (
        input  rd_addr0, rd_addr1,
        input  wr_addr0, wr_data0, wr_ena0,
        input  wr_addr1, wr_data1, wr_ena1,
        input  clear_req,
        output rd_data0, rd_data1, busy, clear_done
    );
endinterface

// File: rtl/register_file_mp.sv
// 2R/2W register file with optional zero register, write bypass and clear sequencer.
module register_file_mp #(
    parameter int N        = 32,
    parameter int A        = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic               clk,
    input logic               rst,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 1 << A;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [A-1:0] idx;
    logic [A-1:0] idx_nxt;
    logic         done_nxt;
    logic         idle;
    logic         clr_en;
    logic         we0;
    logic         we1;
    logic         byp_en;
    logic [N-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            bus.clear_done <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            bus.clear_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == A'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        idle     = (state == IDLE);
        clr_en   = (state == CLEAR);
        bus.busy = clr_en;
    end

    // Writes to a hardwired zero register are squashed here so bypass never sees them.
    assign we0 = bus.wr_ena0 && idle &&
                 !((ZERO_REG != 0) && (bus.wr_addr0 == '0));
    assign we1 = bus.wr_ena1 && idle &&
                 !((ZERO_REG != 0) && (bus.wr_addr1 == '0));
    assign byp_en = (BYPASS != 0) && idle;

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_en) begin
            regs[idx] <= '0;
        end else begin
            if (we0) begin
                regs[bus.wr_addr0] <= bus.wr_data0;
            end
            if (we1) begin
                regs[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    always_comb begin
        bus.rd_data0 = regs[bus.rd_addr0];
        if (byp_en && we1 && (bus.rd_addr0 == bus.wr_addr1)) begin
            bus.rd_data0 = bus.wr_data1;
        end else if (byp_en && we0 && (bus.rd_addr0 == bus.wr_addr0)) begin
            bus.rd_data0 = bus.wr_data0;
        end
        if ((ZERO_REG != 0) && (bus.rd_addr0 == '0)) begin
            bus.rd_data0 = '0;
        end
    end

    always_comb begin
        bus.rd_data1 = regs[bus.rd_addr1];
        if (byp_en && we1 && (bus.rd_addr1 == bus.wr_addr1)) begin
            bus.rd_data1 = bus.wr_data1;
        end else if (byp_en && we0 && (bus.rd_addr1 == bus.wr_addr0)) begin
            bus.rd_data1 = bus.wr_data0;
        end
        if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) begin
            bus.rd_data1 = '0;
        end
    end
endmodule
